// File: rtl/nlb_rdwr_issue_pkg.sv
// nlb_rdwr_issue shared types.
// Channel header layouts, error codes and write FSM states.
package nlb_issue_pkg;

  localparam int P_ADDR_LMT    = 20;
  localparam int P_PADDR_W     = 42;
  localparam int P_MDATA       = 14;
  localparam int P_MAX_RD_PEND = 256;
  localparam int TID_W         = 16;
  localparam int LEN_W         = 2;
  localparam int CL_W          = 512;
  localparam int CRED_W        = 10;

  typedef struct packed {
    logic [P_PADDR_W-1:0] addr;
    logic [LEN_W-1:0]     len;
    logic [TID_W-1:0]     mdata;
  } t_c0_hdr;

  typedef struct packed {
    logic [P_PADDR_W-1:0] addr;
    logic                 sop;
    logic [LEN_W-1:0]     len;
    logic [TID_W-1:0]     mdata;
  } t_c1_hdr;

  typedef enum logic [3:0] {
    E_NONE     = 4'd0,
    E_CRED_OVF = 4'd1,
    E_SOP      = 4'd2,
    E_RD_TAG   = 4'd3,
    E_WR_TAG   = 4'd4
  } t_err;

  typedef enum logic {
    WIDLE = 1'b0,
    WPKT  = 1'b1
  } t_wstate;

  // Length fields carry count-1; this restores the CL count.
  function automatic logic [LEN_W:0] cl_cnt(
    input logic [LEN_W-1:0] len
  );
    return {1'b0, len} + (LEN_W+1)'(1);
  endfunction

endpackage

// File: rtl/nlb_rdwr_issue_if.sv
// Test-engine side request/response bundle.
// master = test engine, slave = issue stage.
interface nlb_rdwr_issue_if
  import nlb_issue_pkg::*;
#(
  parameter int ADDR_LMT = P_ADDR_LMT
);

  logic                rw2ab_RdEn;
  logic [ADDR_LMT-1:0] rw2ab_RdAddr;
  logic [TID_W-1:0]    rw2ab_RdTID;
  logic [LEN_W-1:0]    rw2ab_RdLen;
  logic                rw2ab_RdSop;
  logic                ab2rw_RdSent;

  logic                rw2ab_WrEn;
  logic [ADDR_LMT-1:0] rw2ab_WrAddr;
  logic [TID_W-1:0]    rw2ab_WrTID;
  logic [CL_W-1:0]     rw2ab_WrDin;
  logic [LEN_W-1:0]    rw2ab_WrLen;
  logic                rw2ab_WrSop;
  logic                ab2rw_WrSent;
  logic                ab2rw_WrAlmFull;

  logic                ab2rw_RdRspValid;
  logic [TID_W-1:0]    ab2rw_RdRsp;
  logic [1:0]          ab2rw_RdRspCLnum;
  logic [CL_W-1:0]     ab2rw_RdData;
  logic                ab2rw_WrRspValid;
  logic [TID_W-1:0]    ab2rw_WrRsp;
  logic                ab2rw_WrRspFormat;
  logic [1:0]          ab2rw_WrRspCLnum;
  logic                ab2rw_ErrorValid;
  logic [3:0]          ab2rw_ErrorCode;

  modport master (
    output rw2ab_RdEn, rw2ab_RdAddr, rw2ab_RdTID,
    output rw2ab_RdLen, rw2ab_RdSop,
    output rw2ab_WrEn, rw2ab_WrAddr, rw2ab_WrTID,
    output rw2ab_WrDin, rw2ab_WrLen, rw2ab_WrSop,
    input  ab2rw_RdSent, ab2rw_WrSent, ab2rw_WrAlmFull,
    input  ab2rw_RdRspValid, ab2rw_RdRsp,
    input  ab2rw_RdRspCLnum, ab2rw_RdData,
    input  ab2rw_WrRspValid, ab2rw_WrRsp,
    input  ab2rw_WrRspFormat, ab2rw_WrRspCLnum,
    input  ab2rw_ErrorValid, ab2rw_ErrorCode
  );

  modport slave (
    input  rw2ab_RdEn, rw2ab_RdAddr, rw2ab_RdTID,
    input  rw2ab_RdLen, rw2ab_RdSop,
    input  rw2ab_WrEn, rw2ab_WrAddr, rw2ab_WrTID,
    input  rw2ab_WrDin, rw2ab_WrLen, rw2ab_WrSop,
    output ab2rw_RdSent, ab2rw_WrSent, ab2rw_WrAlmFull,
    output ab2rw_RdRspValid, ab2rw_RdRsp,
    output ab2rw_RdRspCLnum, ab2rw_RdData,
    output ab2rw_WrRspValid, ab2rw_WrRsp,
    output ab2rw_WrRspFormat, ab2rw_WrRspCLnum,
    output ab2rw_ErrorValid, ab2rw_ErrorCode
  );

endinterface

// File: rtl/nlb_rdwr_issue_rd_credit.sv
// Outstanding-read credit counter.
// Gates read accepts and flags responses beyond the credit pool.
module nlb_rd_credit
  import nlb_issue_pkg::*;
#(
  parameter int MAX_RD_PEND = P_MAX_RD_PEND
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [LEN_W-1:0] len,
  input  logic             blocked,
  input  logic             rsp,
  output logic             accept,
  output logic             ovf
);

  localparam logic [CRED_W-1:0] MAX_C = CRED_W'(MAX_RD_PEND);

  logic [CRED_W-1:0] cred_q;
  logic [CRED_W-1:0] cred_d;
  logic [CRED_W-1:0] need;

  always_comb begin
    need   = CRED_W'(cl_cnt(len));
    accept = req & ~blocked & (cred_q >= need);
    ovf    = rsp & (cred_q == MAX_C);
    cred_d = cred_q;
    if (accept) cred_d = cred_d - need;
    // A surplus response saturates rather than wrapping the pool.
    if (rsp & ~ovf) cred_d = cred_d + CRED_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cred_q <= MAX_C;
    else        cred_q <= cred_d;
  end

endmodule

// File: rtl/nlb_rdwr_issue.sv
// Read/write issue stage between the test engine and channels 0/1.
// Registers channel requests, tracks read credit, flags errors.
module nlb_rdwr_issue
  import nlb_issue_pkg::*;
#(
  parameter int ADDR_LMT    = P_ADDR_LMT,
  parameter int PADDR_W     = P_PADDR_W,
  parameter int MDATA       = P_MDATA,
  parameter int MAX_RD_PEND = P_MAX_RD_PEND
) (
  input  logic                Clk_400,
  input  logic                test_Resetb,
  input  logic [PADDR_W-1:0]  cfg_BaseAddr,
  nlb_rdwr_issue_if.slave     rw,
  output logic                c0_TxValid,
  output logic [PADDR_W+17:0] c0_TxHdr,
  input  logic                c0_TxAlmFull,
  output logic                c1_TxValid,
  output logic [PADDR_W+18:0] c1_TxHdr,
  output logic [CL_W-1:0]     c1_TxData,
  input  logic                c1_TxAlmFull,
  input  logic                c0_RxValid,
  input  logic [TID_W-1:0]    c0_RxMdata,
  input  logic [1:0]          c0_RxCLnum,
  input  logic [CL_W-1:0]     c0_RxData,
  input  logic                c1_RxValid,
  input  logic [TID_W-1:0]    c1_RxMdata,
  input  logic                c1_RxFormat,
  input  logic [1:0]          c1_RxCLnum
);

  if (PADDR_W != P_PADDR_W) begin : g_bad_paddr
    $error("PADDR_W must match header struct layout");
  end
  if (MDATA < 1 || MDATA > TID_W) begin : g_bad_mdata
    $error("MDATA out of range");
  end
  if (ADDR_LMT > PADDR_W) begin : g_bad_addr
    $error("ADDR_LMT wider than PADDR_W");
  end
  if (MAX_RD_PEND < 4 || MAX_RD_PEND > 512) begin : g_bad_pend
    $error("MAX_RD_PEND out of range");
  end

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert asynchronously, release on the core clock.
  always_ff @(posedge Clk_400 or negedge test_Resetb) begin
    if (!test_Resetb) rst_sync_q <= '0;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [ADDR_LMT-1:0] rd_addr;
  logic [ADDR_LMT-1:0] wr_addr;
  logic                rd_acc;
  logic                cred_ovf;
  logic                wr_en;
  logic                wr_acc;
  logic                sop_err;
  logic                rd_tag_err;
  logic                wr_tag_err;
  logic                unused_ok;

  assign rd_addr   = rw.rw2ab_RdAddr;
  assign wr_addr   = rw.rw2ab_WrAddr;
  assign wr_en     = rw.rw2ab_WrEn & rst_n;
  assign unused_ok = rw.rw2ab_RdSop;

  nlb_rd_credit #(
    .MAX_RD_PEND (MAX_RD_PEND)
  ) u_rd_credit (
    .clk     (Clk_400),
    .rst_n   (rst_n),
    .req     (rw.rw2ab_RdEn & rst_n),
    .len     (rw.rw2ab_RdLen),
    .blocked (c0_TxAlmFull),
    .rsp     (c0_RxValid),
    .accept  (rd_acc),
    .ovf     (cred_ovf)
  );

  t_wstate          wstate_q, wstate_d;
  logic [LEN_W-1:0] wrem_q, wrem_d;

  // Mid-packet beats ignore almost-full so packets never split.
  always_comb begin
    wstate_d = wstate_q;
    wrem_d   = wrem_q;
    wr_acc   = 1'b0;
    sop_err  = 1'b0;
    unique case (wstate_q)
      WIDLE: begin
        if (wr_en & ~c1_TxAlmFull & rw.rw2ab_WrSop) begin
          wr_acc = 1'b1;
          if (rw.rw2ab_WrLen != '0) begin
            wstate_d = WPKT;
            wrem_d   = rw.rw2ab_WrLen;
          end
        end
      end
      WPKT: begin
        if (wr_en & rw.rw2ab_WrSop) begin
          sop_err  = 1'b1;
          wstate_d = WIDLE;
          wrem_d   = '0;
        end else if (wr_en) begin
          wr_acc = 1'b1;
          wrem_d = wrem_q - LEN_W'(1);
          if (wrem_q == LEN_W'(1)) wstate_d = WIDLE;
        end
      end
      default: wstate_d = WIDLE;
    endcase
  end

  logic              c0_vld_q, c0_vld_d;
  t_c0_hdr           c0_hdr_q, c0_hdr_d;
  logic              c1_vld_q, c1_vld_d;
  t_c1_hdr           c1_hdr_q, c1_hdr_d;
  logic [CL_W-1:0]   c1_dat_q, c1_dat_d;
  logic              rrsp_vld_q, rrsp_vld_d;
  logic [TID_W-1:0]  rrsp_q, rrsp_d;
  logic [1:0]        rrsp_cl_q, rrsp_cl_d;
  logic [CL_W-1:0]   rrsp_dat_q, rrsp_dat_d;
  logic              wrsp_vld_q, wrsp_vld_d;
  logic [TID_W-1:0]  wrsp_q, wrsp_d;
  logic              wrsp_fmt_q, wrsp_fmt_d;
  logic [1:0]        wrsp_cl_q, wrsp_cl_d;
  t_err              err_q, err_d;

  always_comb begin
    c0_vld_d = rd_acc;
    c0_hdr_d = c0_hdr_q;
    if (rd_acc) begin
      c0_hdr_d.addr  = cfg_BaseAddr + PADDR_W'(rd_addr);
      c0_hdr_d.len   = rw.rw2ab_RdLen;
      c0_hdr_d.mdata = rw.rw2ab_RdTID;
    end
    c1_vld_d = wr_acc;
    c1_hdr_d = c1_hdr_q;
    c1_dat_d = c1_dat_q;
    if (wr_acc) begin
      c1_hdr_d.addr  = cfg_BaseAddr + PADDR_W'(wr_addr);
      c1_hdr_d.sop   = rw.rw2ab_WrSop;
      c1_hdr_d.len   = rw.rw2ab_WrLen;
      c1_hdr_d.mdata = rw.rw2ab_WrTID;
      c1_dat_d       = rw.rw2ab_WrDin;
    end
    rrsp_vld_d = c0_RxValid;
    rrsp_d     = c0_RxValid ? c0_RxMdata : rrsp_q;
    rrsp_cl_d  = c0_RxValid ? c0_RxCLnum : rrsp_cl_q;
    rrsp_dat_d = c0_RxValid ? c0_RxData  : rrsp_dat_q;
    wrsp_vld_d = c1_RxValid;
    wrsp_d     = c1_RxValid ? c1_RxMdata  : wrsp_q;
    wrsp_fmt_d = c1_RxValid ? c1_RxFormat : wrsp_fmt_q;
    wrsp_cl_d  = c1_RxValid ? c1_RxCLnum  : wrsp_cl_q;
    rd_tag_err = c0_RxValid & ~c0_RxMdata[0];
    wr_tag_err = c1_RxValid &  c1_RxMdata[0];
    // First cause sticks; lowest code wins within a cycle.
    err_d = err_q;
    if (err_q == E_NONE) begin
      if (cred_ovf)        err_d = E_CRED_OVF;
      else if (sop_err)    err_d = E_SOP;
      else if (rd_tag_err) err_d = E_RD_TAG;
      else if (wr_tag_err) err_d = E_WR_TAG;
    end
  end

  always_ff @(posedge Clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q   <= WIDLE;
      wrem_q     <= '0;
      c0_vld_q   <= 1'b0;
      c0_hdr_q   <= '0;
      c1_vld_q   <= 1'b0;
      c1_hdr_q   <= '0;
      c1_dat_q   <= '0;
      rrsp_vld_q <= 1'b0;
      rrsp_q     <= '0;
      rrsp_cl_q  <= '0;
      rrsp_dat_q <= '0;
      wrsp_vld_q <= 1'b0;
      wrsp_q     <= '0;
      wrsp_fmt_q <= 1'b0;
      wrsp_cl_q  <= '0;
      err_q      <= E_NONE;
    end else begin
      wstate_q   <= wstate_d;
      wrem_q     <= wrem_d;
      c0_vld_q   <= c0_vld_d;
      c0_hdr_q   <= c0_hdr_d;
      c1_vld_q   <= c1_vld_d;
      c1_hdr_q   <= c1_hdr_d;
      c1_dat_q   <= c1_dat_d;
      rrsp_vld_q <= rrsp_vld_d;
      rrsp_q     <= rrsp_d;
      rrsp_cl_q  <= rrsp_cl_d;
      rrsp_dat_q <= rrsp_dat_d;
      wrsp_vld_q <= wrsp_vld_d;
      wrsp_q     <= wrsp_d;
      wrsp_fmt_q <= wrsp_fmt_d;
      wrsp_cl_q  <= wrsp_cl_d;
      err_q      <= err_d;
    end
  end

  assign c0_TxValid = c0_vld_q;
  assign c0_TxHdr   = c0_hdr_q;
  assign c1_TxValid = c1_vld_q;
  assign c1_TxHdr   = c1_hdr_q;
  assign c1_TxData  = c1_dat_q;

  assign rw.ab2rw_RdSent      = rd_acc;
  assign rw.ab2rw_WrSent      = wr_acc;
  assign rw.ab2rw_WrAlmFull   = c1_TxAlmFull |
                                ((wstate_q == WIDLE) & c1_TxAlmFull);
  assign rw.ab2rw_RdRspValid  = rrsp_vld_q;
  assign rw.ab2rw_RdRsp       = rrsp_q;
  assign rw.ab2rw_RdRspCLnum  = rrsp_cl_q;
  assign rw.ab2rw_RdData      = rrsp_dat_q;
  assign rw.ab2rw_WrRspValid  = wrsp_vld_q;
  assign rw.ab2rw_WrRsp       = wrsp_q;
  assign rw.ab2rw_WrRspFormat = wrsp_fmt_q;
  assign rw.ab2rw_WrRspCLnum  = wrsp_cl_q;
  assign rw.ab2rw_ErrorValid  = (err_q != E_NONE);
  assign rw.ab2rw_ErrorCode   = err_q;

endmodule

// File: tb/tb_nlb_rdwr_issue.sv
// Directed bench for nlb_rdwr_issue.
// Small credit pool (4) to reach the limit quickly.
module tb_nlb_rdwr_issue;

  logic         clk = 1'b0;
  logic         rst_b;
  logic [41:0]  base;
  logic         c0_txv, c0_alm;
  logic [59:0]  c0_hdr;
  logic         c1_txv, c1_alm;
  logic [60:0]  c1_hdr;
  logic [511:0] c1_dat;
  logic         c0_rxv;
  logic [15:0]  c0_rxm;
  logic [1:0]   c0_rxcl;
  logic [511:0] c0_rxd;
  logic         c1_rxv;
  logic [15:0]  c1_rxm;
  logic         c1_rxf;
  logic [1:0]   c1_rxcl;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nlb_rdwr_issue_if #(.ADDR_LMT(20)) rw ();

  nlb_rdwr_issue #(
    .ADDR_LMT    (20),
    .PADDR_W     (42),
    .MDATA       (14),
    .MAX_RD_PEND (4)
  ) dut (
    .Clk_400      (clk),
    .test_Resetb  (rst_b),
    .cfg_BaseAddr (base),
    .rw           (rw),
    .c0_TxValid   (c0_txv),
    .c0_TxHdr     (c0_hdr),
    .c0_TxAlmFull (c0_alm),
    .c1_TxValid   (c1_txv),
    .c1_TxHdr     (c1_hdr),
    .c1_TxData    (c1_dat),
    .c1_TxAlmFull (c1_alm),
    .c0_RxValid   (c0_rxv),
    .c0_RxMdata   (c0_rxm),
    .c0_RxCLnum   (c0_rxcl),
    .c0_RxData    (c0_rxd),
    .c1_RxValid   (c1_rxv),
    .c1_RxMdata   (c1_rxm),
    .c1_RxFormat  (c1_rxf),
    .c1_RxCLnum   (c1_rxcl)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rw.rw2ab_RdEn   = 1'b0;
    rw.rw2ab_RdAddr = '0;
    rw.rw2ab_RdTID  = '0;
    rw.rw2ab_RdLen  = '0;
    rw.rw2ab_RdSop  = 1'b0;
    rw.rw2ab_WrEn   = 1'b0;
    rw.rw2ab_WrAddr = '0;
    rw.rw2ab_WrTID  = '0;
    rw.rw2ab_WrDin  = '0;
    rw.rw2ab_WrLen  = '0;
    rw.rw2ab_WrSop  = 1'b0;
    c0_alm  = 1'b0;
    c1_alm  = 1'b0;
    c0_rxv  = 1'b0;
    c0_rxm  = '0;
    c0_rxcl = '0;
    c0_rxd  = '0;
    c1_rxv  = 1'b0;
    c1_rxm  = '0;
    c1_rxf  = 1'b0;
    c1_rxcl = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_b = 1'b0;
    cyc();
    cyc();
    rst_b = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic rd(
    input logic [19:0] a,
    input logic [1:0]  l,
    input logic [15:0] t
  );
    rw.rw2ab_RdEn   = 1'b1;
    rw.rw2ab_RdAddr = a;
    rw.rw2ab_RdLen  = l;
    rw.rw2ab_RdTID  = t;
    rw.rw2ab_RdSop  = 1'b1;
  endtask

  task automatic wr(
    input logic [19:0] a,
    input logic        s,
    input logic [1:0]  l,
    input logic [15:0] t
  );
    rw.rw2ab_WrEn   = 1'b1;
    rw.rw2ab_WrAddr = a;
    rw.rw2ab_WrSop  = s;
    rw.rw2ab_WrLen  = l;
    rw.rw2ab_WrTID  = t;
    rw.rw2ab_WrDin  = {64'hFEED_0000_0000_0000 | 64'(a),
                       384'h0,
                       64'h1234_0000_0000_0000 | 64'(a)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    base  = 42'h1000;
    rst_b = 1'b0;
    idle();
    cyc();
    cyc();
    chk("rst_c0v", c0_txv, 0);
    chk("rst_c1v", c1_txv, 0);
    chk("rst_rrv", rw.ab2rw_RdRspValid, 0);
    chk("rst_wrv", rw.ab2rw_WrRspValid, 0);
    chk("rst_errv", rw.ab2rw_ErrorValid, 0);
    chk("rst_errc", rw.ab2rw_ErrorCode, 0);
    chk("rst_c0hdr", c0_hdr, 0);
    rst_b = 1'b1;
    repeat (3) cyc();

    // single read, base added
    rd(20'h5, 2'd0, 16'hA001);
    #1 chk("rd1_sent", rw.ab2rw_RdSent, 1);
    cyc();
    chk("rd1_c0v", c0_txv, 1);
    chk("rd1_hdr", c0_hdr, 64'({42'h1005, 2'd0, 16'hA001}));
    for (int i = 0; i < 3; i++) begin
      rd(20'(6 + i), 2'd0, 16'hA001);
      #1 chk("rd_fill_sent", rw.ab2rw_RdSent, 1);
      cyc();
    end
    rd(20'h9, 2'd0, 16'hA003);
    #1 chk("rd5_blocked", rw.ab2rw_RdSent, 0);
    cyc();
    chk("rd5_no_c0v", c0_txv, 0);
    c0_rxv  = 1'b1;
    c0_rxm  = 16'h0001;
    c0_rxcl = 2'd2;
    #1 chk("rd5_same_cyc", rw.ab2rw_RdSent, 0);
    cyc();
    c0_rxv = 1'b0;
    chk("rrsp_v", rw.ab2rw_RdRspValid, 1);
    chk("rrsp_m", rw.ab2rw_RdRsp, 16'h0001);
    chk("rrsp_cl", rw.ab2rw_RdRspCLnum, 2);
    rw.rw2ab_RdLen = 2'd1;
    #1 chk("rd_len2_block", rw.ab2rw_RdSent, 0);
    rw.rw2ab_RdLen = 2'd0;
    #1 chk("rd5_sent", rw.ab2rw_RdSent, 1);
    cyc();
    rw.rw2ab_RdEn = 1'b0;
    chk("rd5_c0v", c0_txv, 1);
    chk("rd5_hdr", c0_hdr, 64'({42'h1009, 2'd0, 16'hA003}));

    c0_rxv = 1'b1;
    repeat (4) cyc();
    c0_rxv = 1'b0;
    chk("no_err_yet", rw.ab2rw_ErrorValid, 0);
    rd(20'h20, 2'd3, 16'hA005);
    #1 chk("rd4cl_sent", rw.ab2rw_RdSent, 1);
    cyc();
    rw.rw2ab_RdLen = 2'd0;
    #1 chk("rd4cl_drained", rw.ab2rw_RdSent, 0);
    chk("rd4cl_hdr", c0_hdr, 64'({42'h1020, 2'd3, 16'hA005}));
    rw.rw2ab_RdEn = 1'b0;
    c0_rxv = 1'b1;
    repeat (4) cyc();
    chk("cred_full_ok", rw.ab2rw_ErrorValid, 0);
    cyc();
    c0_rxv = 1'b0;
    chk("ovf_errv", rw.ab2rw_ErrorValid, 1);
    chk("ovf_code", rw.ab2rw_ErrorCode, 1);

    // 4-CL write with almost-full rising mid-packet
    do_reset();
    chk("rst2_errc", rw.ab2rw_ErrorCode, 0);
    wr(20'h10, 1'b1, 2'd3, 16'hB000);
    #1 chk("wr0_sent", rw.ab2rw_WrSent, 1);
    cyc();
    chk("wr0_c1v", c1_txv, 1);
    chk("wr0_hdr", c1_hdr, 64'({42'h1010, 1'b1, 2'd3, 16'hB000}));
    chk("wr0_dlo", c1_dat[63:0], 64'h1234_0000_0000_0010);
    chk("wr0_dhi", c1_dat[511:448], 64'hFEED_0000_0000_0010);
    wr(20'h11, 1'b0, 2'd3, 16'hB000);
    #1 chk("wr1_sent", rw.ab2rw_WrSent, 1);
    cyc();
    c1_alm = 1'b1;
    wr(20'h12, 1'b0, 2'd3, 16'hB000);
    #1 chk("wr2_alm_sent", rw.ab2rw_WrSent, 1);
    cyc();
    wr(20'h13, 1'b0, 2'd3, 16'hB000);
    #1 chk("wr3_alm_sent", rw.ab2rw_WrSent, 1);
    cyc();
    chk("wr3_hdr", c1_hdr, 64'({42'h1013, 1'b0, 2'd3, 16'hB000}));
    wr(20'h30, 1'b1, 2'd0, 16'hB002);
    #1 chk("wr_sop_held", rw.ab2rw_WrSent, 0);
    chk("wr_almfull", rw.ab2rw_WrAlmFull, 1);
    cyc();
    chk("wr_held_c1v", c1_txv, 0);
    c1_alm = 1'b0;
    #1 chk("wr_sop_go", rw.ab2rw_WrSent, 1);
    chk("wr_almfull_lo", rw.ab2rw_WrAlmFull, 0);
    cyc();
    chk("wr_go_c1v", c1_txv, 1);
    rw.rw2ab_WrEn = 1'b0;
    cyc();

    // Sop inside a packet
    wr(20'h40, 1'b1, 2'd3, 16'hB004);
    #1 chk("sope_first", rw.ab2rw_WrSent, 1);
    cyc();
    #1 chk("sope_rej", rw.ab2rw_WrSent, 0);
    cyc();
    chk("sope_errv", rw.ab2rw_ErrorValid, 1);
    chk("sope_code", rw.ab2rw_ErrorCode, 2);
    rw.rw2ab_WrSop = 1'b0;
    #1 chk("idle_nosop", rw.ab2rw_WrSent, 0);
    wr(20'h44, 1'b1, 2'd0, 16'hB006);
    #1 chk("idle_sop_ok", rw.ab2rw_WrSent, 1);
    cyc();
    rw.rw2ab_WrEn = 1'b0;

    // read response tagged as write
    do_reset();
    rd(20'h1, 2'd0, 16'h0003);
    cyc();
    rw.rw2ab_RdEn = 1'b0;
    c0_rxv = 1'b1;
    c0_rxm = 16'h0002;
    c0_rxd = {64'hBEEF, 448'h0};
    cyc();
    c0_rxv = 1'b0;
    chk("rtag_v", rw.ab2rw_RdRspValid, 1);
    chk("rtag_m", rw.ab2rw_RdRsp, 16'h0002);
    chk("rtag_d", rw.ab2rw_RdData[511:448], 64'hBEEF);
    chk("rtag_code", rw.ab2rw_ErrorCode, 3);

    // write response tagged as read
    do_reset();
    c1_rxv  = 1'b1;
    c1_rxm  = 16'h0001;
    c1_rxf  = 1'b1;
    c1_rxcl = 2'd3;
    cyc();
    c1_rxv = 1'b0;
    chk("wtag_v", rw.ab2rw_WrRspValid, 1);
    chk("wtag_m", rw.ab2rw_WrRsp, 16'h0001);
    chk("wtag_f", rw.ab2rw_WrRspFormat, 1);
    chk("wtag_cl", rw.ab2rw_WrRspCLnum, 3);
    chk("wtag_code", rw.ab2rw_ErrorCode, 4);

    // reset in the middle of a packet
    do_reset();
    wr(20'h40, 1'b1, 2'd3, 16'hB008);
    cyc();
    wr(20'h41, 1'b0, 2'd3, 16'hB008);
    cyc();
    chk("mid_c1v_pre", c1_txv, 1);
    #2 rst_b = 1'b0;
    #1 chk("mid_c1v_rst", c1_txv, 0);
    chk("mid_c0v_rst", c0_txv, 0);
    chk("mid_sent_rst", rw.ab2rw_WrSent, 0);
    cyc();
    cyc();
    rst_b = 1'b1;
    wr(20'h42, 1'b0, 2'd3, 16'hB008);
    repeat (3) cyc();
    #1 chk("stale_rej", rw.ab2rw_WrSent, 0);
    cyc();
    chk("stale_c1v", c1_txv, 0);
    wr(20'h50, 1'b1, 2'd0, 16'hB00A);
    #1 chk("fresh_sent", rw.ab2rw_WrSent, 1);
    cyc();
    rw.rw2ab_WrEn = 1'b0;
    chk("fresh_c1v", c1_txv, 1);
    chk("fresh_hdr", c1_hdr, 64'({42'h1050, 1'b1, 2'd0, 16'hB00A}));
    cyc();
    chk("fresh_c1v_off", c1_txv, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
